// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: program load port, run control, instruction stream with jump redirect, and status.
interface instr_fetch_if #(
    parameter int IW = 12,
    parameter int AW = 4
);
    logic          prog_clr;
    logic          load_en;
    logic [IW-1:0] load_data;
    logic          load_last;
    logic          start;
    logic          stop;
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic          instr_ready;
    logic          jump_en;
    logic [AW-1:0] jump_addr;
    logic [AW-1:0] pc;
    logic [AW:0]   prog_len;
    logic          busy;
    logic          halted;

    // Fetch unit side.
    modport master (
        input  prog_clr, load_en, load_data, load_last, start, stop,
        input  instr_ready, jump_en, jump_addr,
        output instr_out, instr_valid, pc, prog_len, busy, halted
    );

    // Core / loader side.
    modport slave (
        output prog_clr, load_en, load_data, load_last, start, stop,
        output instr_ready, jump_en, jump_addr,
        input  instr_out, instr_valid, pc, prog_len, busy, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Program buffer streaming IW-bit words to the core under valid/ready, 1-cycle start latency, jump/stop redirect.
// Define HALT_DETECT_EN to stop streaming at words whose top nibble is 4'b1111 (HALT state).
module instr_fetch #(
    parameter int IW    = 12,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

`ifdef HALT_DETECT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [IW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic          frozen;
    state_t        state, nxt_state;
    logic [AW-1:0] pc, nxt_pc;
    logic [AW:0]   pc_inc;
    logic [AW-1:0] pc_wrap;
    logic [AW-1:0] jump_tgt;
    logic          load_ok;
    logic          start_ok;

    // The write pointer doubles as program length: both equal the number of stored words.
    assign load_ok  = (state == IDLE) && bus.load_en && !bus.prog_clr && !frozen && (wr_ptr != FULL);
    assign start_ok = bus.start && !bus.load_en && !bus.prog_clr && (wr_ptr != '0);
    assign pc_inc   = {1'b0, pc} + (AW+1)'(1);
    assign pc_wrap  = (pc_inc == wr_ptr) ? '0 : pc_inc[AW-1:0];
    assign jump_tgt = ({1'b0, bus.jump_addr} < wr_ptr) ? bus.jump_addr : '0;

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[wr_ptr[AW-1:0]] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            frozen <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.prog_clr) begin
                wr_ptr <= '0;
                frozen <= 1'b0;
            end else if (load_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
                frozen <= bus.load_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= nxt_state;
            pc    <= nxt_pc;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_pc    = pc;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    nxt_state = RUN;
                    nxt_pc    = '0;
                end
            end
            RUN: begin
                // Valid is always high in RUN, so ready alone marks a transfer.
                if (bus.stop) begin
                    nxt_state = IDLE;
                    nxt_pc    = '0;
                end else if (bus.jump_en) begin
                    nxt_pc = jump_tgt;
                end else if (bus.instr_ready) begin
                    nxt_pc = pc_wrap;
                end
            end
`ifdef HALT_DETECT_EN
            HALT: begin
                if (bus.stop) begin
                    nxt_state = IDLE;
                    nxt_pc    = '0;
                end
            end
`endif
            default: begin
                nxt_state = IDLE;
                nxt_pc    = '0;
            end
        endcase
`ifdef HALT_DETECT_EN
        // A marker about to be presented parks the stream with pc on the marker.
        if ((nxt_state == RUN) && (mem[nxt_pc][IW-1:IW-4] == 4'b1111)) begin
            nxt_state = HALT;
        end
`endif
    end

    always_comb begin
        bus.instr_valid = (state == RUN);
        bus.busy        = (state == RUN);
        bus.instr_out   = (state == RUN) ? mem[pc] : '0;
        bus.pc          = pc;
        bus.prog_len    = wr_ptr;
`ifdef HALT_DETECT_EN
        bus.halted      = (state == HALT);
`else
        bus.halted      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written corner sequences, then random traffic vs a reference model.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    instr_fetch_if #(.IW(12), .AW(4)) bus ();

    instr_fetch #(.IW(12), .DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: program as an array plus a length, run/halt flags and a word index.
    logic [11:0] m_mem [16];
    int          m_len;
    bit          m_frozen, m_run, m_halt;
    int          m_pc;

    typedef struct {
        logic        clr, ld;
        logic [11:0] dat;
        logic        last, st, sp, rdy, jmp;
        logic [3:0]  ja;
        logic        ev;
        logic [11:0] eo;
        logic [3:0]  epc;
        logic [4:0]  elen;
    } vec_t;

    vec_t vt [24];

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_len = 0; m_frozen = 0; m_run = 0; m_halt = 0; m_pc = 0;
    endtask

    task automatic model_update();
        if (!m_run && !m_halt) begin
            if (bus.prog_clr) begin
                m_len = 0; m_frozen = 0;
            end else if (bus.load_en) begin
                if (!m_frozen && m_len < 16) begin
                    m_mem[m_len] = bus.load_data;
                    m_len++;
                    m_frozen = bus.load_last;
                end
            end else if (bus.start && m_len > 0) begin
                m_run = 1; m_pc = 0;
            end
        end else if (m_run) begin
            if (bus.stop) begin
                m_run = 0; m_pc = 0;
            end else if (bus.jump_en) begin
                m_pc = (int'(bus.jump_addr) < m_len) ? int'(bus.jump_addr) : 0;
            end else if (bus.instr_ready) begin
                m_pc = (m_pc + 1) % m_len;
            end
        end else if (bus.stop) begin
            m_halt = 0; m_pc = 0;
        end
`ifdef HALT_DETECT_EN
        if (m_run && m_mem[m_pc][11:8] == 4'hF) begin
            m_run = 0; m_halt = 1;
        end
`endif
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.prog_clr = 0; bus.load_en = 0; bus.load_data = '0; bus.load_last = 0;
        bus.start = 0; bus.stop = 0; bus.instr_ready = 0; bus.jump_en = 0; bus.jump_addr = '0;
    endtask

    task automatic check_model();
        chk("m_valid", bus.instr_valid, m_run);
        chk("m_busy", bus.busy, m_run);
        chk("m_out", bus.instr_out, m_run ? m_mem[m_pc] : 0);
        chk("m_pc", bus.pc, m_pc);
        chk("m_len", bus.prog_len, m_len);
        chk("m_halted", bus.halted, m_halt);
    endtask

    task automatic load_word(input logic [11:0] d, input logic last);
        idle_inputs();
        bus.load_en = 1; bus.load_data = d; bus.load_last = last;
        tick();
    endtask

    initial begin
        logic [11:0] wa, wb, wc;
        wa = 12'h0A1; wb = 12'h0B2; wc = 12'h0C3;
        //         clr ld  dat     last st  sp  rdy jmp ja     ev  eo     epc   elen
        vt[0]  = '{1, 0, 12'h000, 0, 0, 0, 0, 0, 4'd0,  0, 12'h0, 4'd0, 5'd0};
        vt[1]  = '{0, 1, wa,      0, 0, 0, 0, 0, 4'd0,  0, 12'h0, 4'd0, 5'd1};
        vt[2]  = '{0, 1, wb,      0, 0, 0, 0, 0, 4'd0,  0, 12'h0, 4'd0, 5'd2};
        vt[3]  = '{0, 1, wc,      1, 0, 0, 0, 0, 4'd0,  0, 12'h0, 4'd0, 5'd3};
        vt[4]  = '{0, 0, 12'h000, 0, 1, 0, 1, 0, 4'd0,  1, wa,    4'd0, 5'd3};
        vt[5]  = '{0, 0, 12'h000, 0, 0, 0, 1, 0, 4'd0,  1, wb,    4'd1, 5'd3};
        vt[6]  = '{0, 0, 12'h000, 0, 0, 0, 1, 0, 4'd0,  1, wc,    4'd2, 5'd3};
        vt[7]  = '{0, 0, 12'h000, 0, 0, 0, 1, 0, 4'd0,  1, wa,    4'd0, 5'd3};
        vt[8]  = '{0, 0, 12'h000, 0, 0, 0, 1, 0, 4'd0,  1, wb,    4'd1, 5'd3};
        vt[9]  = '{0, 0, 12'h000, 0, 0, 0, 0, 0, 4'd0,  1, wb,    4'd1, 5'd3};
        vt[10] = '{0, 0, 12'h000, 0, 0, 0, 0, 0, 4'd0,  1, wb,    4'd1, 5'd3};
        vt[11] = '{0, 0, 12'h000, 0, 0, 0, 0, 0, 4'd0,  1, wb,    4'd1, 5'd3};
        vt[12] = '{0, 0, 12'h000, 0, 0, 0, 0, 0, 4'd0,  1, wb,    4'd1, 5'd3};
        vt[13] = '{0, 0, 12'h000, 0, 0, 0, 1, 0, 4'd0,  1, wc,    4'd2, 5'd3};
        vt[14] = '{0, 0, 12'h000, 0, 0, 0, 1, 0, 4'd0,  1, wa,    4'd0, 5'd3};
        vt[15] = '{0, 0, 12'h000, 0, 0, 0, 0, 1, 4'd2,  1, wc,    4'd2, 5'd3};
        vt[16] = '{0, 0, 12'h000, 0, 0, 0, 0, 1, 4'd9,  1, wa,    4'd0, 5'd3};
        vt[17] = '{0, 0, 12'h000, 0, 0, 0, 1, 1, 4'd1,  1, wb,    4'd1, 5'd3};
        vt[18] = '{0, 0, 12'h000, 0, 0, 1, 1, 1, 4'd2,  0, 12'h0, 4'd0, 5'd3};
        vt[19] = '{0, 1, 12'h555, 0, 0, 0, 0, 0, 4'd0,  0, 12'h0, 4'd0, 5'd3};
        vt[20] = '{0, 1, 12'h555, 0, 1, 0, 0, 0, 4'd0,  0, 12'h0, 4'd0, 5'd3};
        vt[21] = '{0, 0, 12'h000, 0, 0, 0, 0, 1, 4'd1,  0, 12'h0, 4'd0, 5'd3};
        vt[22] = '{0, 0, 12'h000, 0, 1, 0, 0, 0, 4'd0,  1, wa,    4'd0, 5'd3};
        vt[23] = '{0, 0, 12'h000, 0, 0, 1, 0, 0, 4'd0,  0, 12'h0, 4'd0, 5'd3};

        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_out", bus.instr_out, 0);
        chk("rst_pc", bus.pc, 0);
        chk("rst_len", bus.prog_len, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_halted", bus.halted, 0);
        rst = 0;

        // Directed vectors: load/stream/stall/jump/stop and ignored controls.
        for (int i = 0; i < 24; i++) begin
            idle_inputs();
            bus.prog_clr = vt[i].clr; bus.load_en = vt[i].ld; bus.load_data = vt[i].dat;
            bus.load_last = vt[i].last; bus.start = vt[i].st; bus.stop = vt[i].sp;
            bus.instr_ready = vt[i].rdy; bus.jump_en = vt[i].jmp; bus.jump_addr = vt[i].ja;
            tick();
            chk($sformatf("vec%0d_valid", i), bus.instr_valid, vt[i].ev);
            chk($sformatf("vec%0d_out", i), bus.instr_out, vt[i].eo);
            chk($sformatf("vec%0d_pc", i), bus.pc, vt[i].epc);
            chk($sformatf("vec%0d_len", i), bus.prog_len, vt[i].elen);
            chk($sformatf("vec%0d_busy", i), bus.busy, vt[i].ev);
        end

        // Full buffer: extra loads ignored, stream wraps after word 15.
        idle_inputs(); bus.prog_clr = 1; tick();
        for (int i = 0; i < 16; i++) load_word(12'h100 + 12'(i), 0);
        load_word(12'h0EE, 0);
        load_word(12'h0EF, 1);
        chk("full_len", bus.prog_len, 16);
        idle_inputs(); bus.start = 1; bus.instr_ready = 1; tick();
        chk("full_first", bus.instr_out, 12'h100);
        for (int k = 1; k <= 17; k++) begin
            idle_inputs(); bus.instr_ready = 1; tick();
            chk($sformatf("full_out%0d", k), bus.instr_out, 12'h100 + (k % 16));
            chk($sformatf("full_pc%0d", k), bus.pc, k % 16);
        end

        // Asynchronous reset mid-run.
        idle_inputs(); bus.instr_ready = 1; tick();
        #2 rst = 1;
        #1;
        model_reset();
        chk("arst_valid", bus.instr_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_pc", bus.pc, 0);
        chk("arst_len", bus.prog_len, 0);
        #2 rst = 0;
        idle_inputs(); bus.start = 1; tick();
        chk("empty_start_busy", bus.busy, 0);
        chk("empty_start_valid", bus.instr_valid, 0);

        // Halt marker handling.
        load_word(12'h0A1, 0);
        load_word(12'hF00, 0);
        load_word(12'h0B2, 1);
        idle_inputs(); bus.start = 1; tick();
        chk("hm_first", bus.instr_out, 12'h0A1);
        idle_inputs(); bus.instr_ready = 1; tick();
`ifdef HALT_DETECT_EN
        chk("hm_halted", bus.halted, 1);
        chk("hm_valid", bus.instr_valid, 0);
        chk("hm_pc", bus.pc, 1);
        idle_inputs(); bus.instr_ready = 1; bus.jump_en = 1; tick();
        chk("hm_hold", bus.halted, 1);
        idle_inputs(); bus.stop = 1; tick();
        chk("hm_exit_halted", bus.halted, 0);
        chk("hm_exit_pc", bus.pc, 0);
`else
        chk("hm_word", bus.instr_out, 12'hF00);
        chk("hm_valid", bus.instr_valid, 1);
        chk("hm_halted", bus.halted, 0);
        idle_inputs(); bus.instr_ready = 1; tick();
        chk("hm_next", bus.instr_out, 12'h0B2);
        idle_inputs(); bus.stop = 1; tick();
`endif
        check_model();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            idle_inputs();
            bus.prog_clr    = ($urandom_range(0, 99) < 3);
            bus.load_en     = ($urandom_range(0, 99) < 25);
            bus.load_data   = 12'($urandom_range(0, 4095));
            bus.load_last   = ($urandom_range(0, 99) < 10);
            bus.start       = ($urandom_range(0, 99) < 30);
            bus.stop        = ($urandom_range(0, 99) < 4);
            bus.instr_ready = ($urandom_range(0, 99) < 70);
            bus.jump_en     = ($urandom_range(0, 99) < 10);
            bus.jump_addr   = 4'($urandom_range(0, 15));
            tick();
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
